imem_stream_loader: RTL
=======================

Name: imem_stream_loader

Overview:
Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset until a complete, checksum-verified image has been written. It replaces hierarchical memory preloading with a synthesizable load path.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width; maximum image is 2^ADDR_WIDTH words.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at a rising edge
reload  input  1  single-cycle pulse: restart loading from any state
imem_we  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  instruction word
core_rst  output  1  active-high reset to the core; 1 until a good image is loaded
done  output  1  image loaded and checksum matched
error  output  1  load failed (length overflow or checksum mismatch)

Behaviour:
- Reset (rst=0, asynchronous): state=LEN_LO, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0, word counter=0, byte lane=0, checksum accumulator=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word LSB first), then 1 checksum byte = XOR of all data bytes. Length bytes are excluded from the checksum.
- States: LEN_LO -> LEN_HI -> DATA -> CHECK -> DONE | ERR. Each transition is taken on an accepted byte.
- LEN_HI accept:
  - N > 2^ADDR_WIDTH -> ERR.
  - N == 0 -> CHECK; the expected checksum is 0x00.
  - Otherwise -> DATA.
- DATA:
  - Each accepted byte goes into lane 0..3 of the assembly register and is XORed into the accumulator.
  - On accepting lane 3, the next cycle drives imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = word counter. The counter then increments.
  - After word N-1 is written -> CHECK. The next byte is not accepted before that write strobe, so in_ready=0 for that one cycle only.
- in_ready: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERR. Back-to-back bytes, one per cycle, are sustained in DATA.
- CHECK accept:
  - Byte == accumulator -> DONE.
  - Otherwise -> ERR.
- DONE: done=1 and core_rst=0, both registered and asserted in the cycle after the checksum is accepted. They remain until reload or reset.
- ERR: error=1 and core_rst stays 1. Extra input bytes are ignored (in_ready=0).
- reload in any state (including mid-word or mid-image):
  - Next cycle: back to LEN_LO; core_rst=1, done=0, error=0; counters and accumulator cleared.
  - Any partially assembled word is discarded with no write.
  - reload has priority over a simultaneous byte transfer; that byte is dropped.
- Memory contents already written are not cleared by reload or reset; the image is simply overwritten.
- imem_addr wraps at 2^ADDR_WIDTH only in the legal N == 2^ADDR_WIDTH case, on the final increment, and is not used afterwards.
- in_valid with in_ready=0 has no effect. The producer must hold the byte.

Test Plan:
- Nominal load: stream 05 00, then 93 00 50 00 13 01 70 00 b3 81 20 00 23 20 30 00 03 22 00 00, then A1 -> writes to addr 0..4: 00500093, 00700113, 002081b3, 00302023, 00002203; then done=1, core_rst=0. Release the core: after 3 cycles x3 = 12 (0x00C); after the lw, x4 = 12.
- Bad checksum: same image with final byte A0 -> five writes occur, then error=1, done=0, core_rst stays 1, in_ready=0.
- Zero/overflow length: 00 00 00 -> done=1 with no imem_we. 01 04 (N=1025 with ADDR_WIDTH=10) -> error=1 immediately, no writes.
- Handshake stalls: randomly deassert in_valid between every byte of the nominal image -> identical writes and done. Verify in_ready=0 exactly one cycle after each final-word byte.
- Reload mid-word: after 2 data bytes of word 2, pulse reload together with a valid byte -> no write for word 2, core_rst=1, state LEN_LO. A full nominal frame then loads correctly.
- Async reset mid-image: pull rst low between clock edges during DATA -> outputs take reset values immediately, without waiting for a clock edge. After release, the nominal frame loads correctly.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed byte stream into
// 32-bit little-endian words and writes them into instruction memory from address 0.
module imem_stream_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            lane_q, lane_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  core_rst_q, core_rst_d;

    logic                  accept;
    logic [15:0]           len_word;

    // Handshake: a byte moves on a rising edge where in_valid && in_ready.
    // The checksum byte is held off while the final word's write strobe is out.
    assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || ((state_q == S_CHECK) && !we_q);
    assign accept   = in_valid && in_ready;
    assign len_word = {in_data, len_lo_q};

    assign imem_we    = we_q;
    assign imem_addr  = cnt_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        done_d     = done_q;
        error_d    = error_q;
        core_rst_d = core_rst_q;
        if (reload) begin
            state_d    = S_LEN_LO;
            cnt_d      = '0;
            lane_d     = 2'd0;
            csum_d     = 8'h00;
            done_d     = 1'b0;
            error_d    = 1'b0;
            core_rst_d = 1'b1;
        end else begin
            if (we_q) cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (accept) begin
                case (state_q)
                    S_LEN_LO: begin
                        len_lo_d = in_data;
                        state_d  = S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if ({1'b0, len_word} > MAX_WORDS) begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end else if (len_word == 16'd0) begin
                            state_d = S_CHECK;
                        end else begin
                            last_d  = ADDR_WIDTH'(len_word - 16'd1);
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum_d = csum_q ^ in_data;
                        lane_d = lane_q + 2'd1;
                        case (lane_q)
                            2'd0:    asm_d[7:0]   = in_data;
                            2'd1:    asm_d[15:8]  = in_data;
                            2'd2:    asm_d[23:16] = in_data;
                            default: begin
                                wdata_d = {in_data, asm_q};
                                we_d    = 1'b1;
                                if (cnt_q == last_q) state_d = S_CHECK;
                            end
                        endcase
                    end
                    S_CHECK: begin
                        if (in_data == csum_q) begin
                            state_d    = S_DONE;
                            done_d     = 1'b1;
                            core_rst_d = 1'b0;
                        end else begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LEN_LO;
            len_lo_q   <= 8'h00;
            last_q     <= '0;
            cnt_q      <= '0;
            lane_q     <= 2'd0;
            asm_q      <= 24'h0;
            csum_q     <= 8'h00;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
            core_rst_q <= core_rst_d;
        end
    end

endmodule
